// File: rtl/cpu_register_file_mp_if.sv
// ---------------------------------------------------------------------------
// cpu_register_file_mp_if
// Bundles the three request channels of the register file. Each channel
// (read, reserve, write) carries a tag; a tag change marks a new request.
//   master : decode / writeback side (drives requests, sees read results)
//   slave  : the register file itself
// Signals:
//   i_read_tag, i_read_rs1_idx, i_read_rs2_idx   read request
//   o_rs1, o_rs2, o_rs1_busy, o_rs2_busy,
//   o_read_tag                                   read result (1-cycle latency)
//   i_reserve_tag, i_reserve_rd_idx              mark a register pending
//   i_write_tag, i_write_rd_idx, i_rd            writeback
//   o_busy                                       per-register pending vector
// ---------------------------------------------------------------------------
interface cpu_register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int TAG_WIDTH  = 4
);
  localparam int IDX_W = $clog2(REG_COUNT);

  logic [TAG_WIDTH-1:0]  i_read_tag;
  logic [IDX_W-1:0]      i_read_rs1_idx;
  logic [IDX_W-1:0]      i_read_rs2_idx;
  logic [DATA_WIDTH-1:0] o_rs1;
  logic [DATA_WIDTH-1:0] o_rs2;
  logic                  o_rs1_busy;
  logic                  o_rs2_busy;
  logic [TAG_WIDTH-1:0]  o_read_tag;

  logic [TAG_WIDTH-1:0]  i_reserve_tag;
  logic [IDX_W-1:0]      i_reserve_rd_idx;

  logic [TAG_WIDTH-1:0]  i_write_tag;
  logic [IDX_W-1:0]      i_write_rd_idx;
  logic [DATA_WIDTH-1:0] i_rd;

  logic [REG_COUNT-1:0]  o_busy;

  modport master (
    output i_read_tag, i_read_rs1_idx, i_read_rs2_idx,
    output i_reserve_tag, i_reserve_rd_idx,
    output i_write_tag, i_write_rd_idx, i_rd,
    input  o_rs1, o_rs2, o_rs1_busy, o_rs2_busy, o_read_tag, o_busy
  );

  modport slave (
    input  i_read_tag, i_read_rs1_idx, i_read_rs2_idx,
    input  i_reserve_tag, i_reserve_rd_idx,
    input  i_write_tag, i_write_rd_idx, i_rd,
    output o_rs1, o_rs2, o_rs1_busy, o_rs2_busy, o_read_tag, o_busy
  );
endinterface

// File: rtl/cpu_register_file_mp.sv
// ---------------------------------------------------------------------------
// cpu_register_file_mp
// Tag-handshaked integer register file: two read ports, one write port,
// optional same-cycle write-to-read bypass and a pending-write scoreboard.
// Register 0 reads as zero and ignores writes/reserves.
// Ports:
//   i_clock    clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        cpu_register_file_mp_if.slave (read/reserve/write channels,
//              read results, busy vector)
// ---------------------------------------------------------------------------
module cpu_register_file_mp #(
  parameter int          DATA_WIDTH = 32,
  parameter int          REG_COUNT  = 32,
  parameter int          TAG_WIDTH  = 4,
  parameter int          SP_INDEX   = 2,
  parameter logic [31:0] SP_RESET   = 32'h0001_03FC,
  parameter bit          BYPASS     = 1'b1
) (
  input logic                   i_clock,
  input logic                   i_reset_n,
  cpu_register_file_mp_if.slave bus
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam logic [DATA_WIDTH-1:0] SP_INIT = DATA_WIDTH'(SP_RESET);

  logic [TAG_WIDTH-1:0]  read_tag_q;
  logic [TAG_WIDTH-1:0]  reserve_tag_q;
  logic [TAG_WIDTH-1:0]  write_tag_q;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  busy_next;

  logic                  read_fire;
  logic                  reserve_en;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  // Only inequality is compared, so tag wrap-around needs no special case.
  assign read_fire  = (bus.i_read_tag != read_tag_q);
  assign reserve_en = (bus.i_reserve_tag != reserve_tag_q) &&
                      (bus.i_reserve_rd_idx != '0);
  assign write_en   = (bus.i_write_tag != write_tag_q) &&
                      (bus.i_write_rd_idx != '0);

  // Reserve is applied after write so the newer producer keeps the register
  // pending when both hit the same index in one cycle.
  always_comb begin
    busy_next = busy_q;
    if (write_en)   busy_next[bus.i_write_rd_idx]   = 1'b0;
    if (reserve_en) busy_next[bus.i_reserve_rd_idx] = 1'b1;
  end

  always_comb begin
    rs1_data = regs_q[bus.i_read_rs1_idx];
    if (BYPASS && write_en && (bus.i_write_rd_idx == bus.i_read_rs1_idx))
      rs1_data = bus.i_rd;
    if (bus.i_read_rs1_idx == '0)
      rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs_q[bus.i_read_rs2_idx];
    if (BYPASS && write_en && (bus.i_write_rd_idx == bus.i_read_rs2_idx))
      rs2_data = bus.i_rd;
    if (bus.i_read_rs2_idx == '0)
      rs2_data = '0;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        regs_q[i] <= (i == SP_INDEX && i != 0) ? SP_INIT : '0;
      busy_q         <= '0;
      read_tag_q     <= '0;
      reserve_tag_q  <= '0;
      write_tag_q    <= '0;
      bus.o_rs1      <= '0;
      bus.o_rs2      <= '0;
      bus.o_rs1_busy <= 1'b0;
      bus.o_rs2_busy <= 1'b0;
      bus.o_read_tag <= '0;
    end else begin
      // Storing the input tag every cycle equals storing it only on change.
      read_tag_q    <= bus.i_read_tag;
      reserve_tag_q <= bus.i_reserve_tag;
      write_tag_q   <= bus.i_write_tag;
      busy_q        <= busy_next;
      if (write_en)
        regs_q[bus.i_write_rd_idx] <= bus.i_rd;
      if (read_fire) begin
        bus.o_rs1      <= rs1_data;
        bus.o_rs2      <= rs2_data;
        bus.o_rs1_busy <= busy_next[bus.i_read_rs1_idx];
        bus.o_rs2_busy <= busy_next[bus.i_read_rs2_idx];
        bus.o_read_tag <= bus.i_read_tag;
      end
    end
  end

  assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_cpu_register_file_mp.sv
module tb_cpu_register_file_mp;
  logic i_clock = 1'b0;
  logic i_reset_n;
  always #5 i_clock = ~i_clock;

  cpu_register_file_mp_if #(.DATA_WIDTH(32), .REG_COUNT(32), .TAG_WIDTH(4)) bus_a();
  cpu_register_file_mp_if #(.DATA_WIDTH(64), .REG_COUNT(16), .TAG_WIDTH(4)) bus_b();

  cpu_register_file_mp dut_a (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .bus      (bus_a)
  );

  cpu_register_file_mp #(.DATA_WIDTH(64), .REG_COUNT(16), .BYPASS(1'b0)) dut_b (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .bus      (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of instance A: architectural registers, pending set and
  // the last read result, plus the tags the bench has issued.
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic [31:0] m_rs1, m_rs2;
  logic        m_rs1_busy, m_rs2_busy;
  logic [3:0]  m_rtag;
  logic [3:0]  t_rd, t_rs, t_wr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[2]   = 32'h0001_03FC;
    m_busy     = 32'h0;
    m_rs1      = 32'h0;
    m_rs2      = 32'h0;
    m_rs1_busy = 1'b0;
    m_rs2_busy = 1'b0;
    m_rtag     = 4'h0;
    t_rd = 4'h0; t_rs = 4'h0; t_wr = 4'h0;
  endtask

  // Issue one cycle of requests on instance A (called at a negedge, returns
  // at the next negedge) and advance the model.
  task automatic step_a(input bit rd_en, input logic [4:0] r1, input logic [4:0] r2,
                        input bit rs_en, input logic [4:0] rs_idx,
                        input bit wr_en, input logic [4:0] wr_idx,
                        input logic [31:0] data);
    logic [31:0] nb;
    bit wr_live, rs_live;
    if (rd_en) t_rd = t_rd + 4'd1;
    if (rs_en) t_rs = t_rs + 4'd1;
    if (wr_en) t_wr = t_wr + 4'd1;
    bus_a.i_read_tag       = t_rd;
    bus_a.i_read_rs1_idx   = r1;
    bus_a.i_read_rs2_idx   = r2;
    bus_a.i_reserve_tag    = t_rs;
    bus_a.i_reserve_rd_idx = rs_idx;
    bus_a.i_write_tag      = t_wr;
    bus_a.i_write_rd_idx   = wr_idx;
    bus_a.i_rd             = data;
    @(posedge i_clock);
    @(negedge i_clock);
    wr_live = wr_en && (wr_idx != 5'd0);
    rs_live = rs_en && (rs_idx != 5'd0);
    nb = m_busy;
    if (wr_live) nb[wr_idx] = 1'b0;
    if (rs_live) nb[rs_idx] = 1'b1;
    if (rd_en) begin
      m_rs1 = (r1 == 5'd0) ? 32'h0 : (wr_live && wr_idx == r1) ? data : m_reg[r1];
      m_rs2 = (r2 == 5'd0) ? 32'h0 : (wr_live && wr_idx == r2) ? data : m_reg[r2];
      m_rs1_busy = nb[r1];
      m_rs2_busy = nb[r2];
      m_rtag = t_rd;
    end
    if (wr_live) m_reg[wr_idx] = data;
    m_busy = nb;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    bus_a.i_read_tag = '0; bus_a.i_read_rs1_idx = '0; bus_a.i_read_rs2_idx = '0;
    bus_a.i_reserve_tag = '0; bus_a.i_reserve_rd_idx = '0;
    bus_a.i_write_tag = '0; bus_a.i_write_rd_idx = '0; bus_a.i_rd = '0;
    bus_b.i_read_tag = '0; bus_b.i_read_rs1_idx = '0; bus_b.i_read_rs2_idx = '0;
    bus_b.i_reserve_tag = '0; bus_b.i_reserve_rd_idx = '0;
    bus_b.i_write_tag = '0; bus_b.i_write_rd_idx = '0; bus_b.i_rd = '0;
    model_reset();
    #1;
    n_checks++;
    if ({bus_a.o_rs1, bus_a.o_rs2, bus_a.o_rs1_busy, bus_a.o_rs2_busy, bus_a.o_read_tag} !== 70'h0) begin
      n_fail++; $display("FAIL reset_outputs: got rs1=%h rs2=%h tag=%h expected all zero",
                         bus_a.o_rs1, bus_a.o_rs2, bus_a.o_read_tag);
    end
    n_checks++;
    if (bus_a.o_busy !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy: got %h expected 0", bus_a.o_busy);
    end
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    step_a(1, 5'd2, 5'd1, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'h0001_03FC) begin
      n_fail++; $display("FAIL reset_sp: got %h expected 000103fc", bus_a.o_rs1);
    end
    n_checks++;
    if (bus_a.o_rs2 !== 32'h0 || bus_a.o_read_tag !== 4'd1) begin
      n_fail++; $display("FAIL reset_r1: got rs2=%h tag=%h expected 0 and 1", bus_a.o_rs2, bus_a.o_read_tag);
    end
  endtask

  task automatic test_write_read();
    step_a(0, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
    step_a(1, 5'd5, 5'd0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'hDEAD_BEEF || bus_a.o_rs2 !== 32'h0 || bus_a.o_read_tag !== t_rd) begin
      n_fail++; $display("FAIL write_read: got rs1=%h rs2=%h tag=%h expected deadbeef 0 %h",
                         bus_a.o_rs1, bus_a.o_rs2, bus_a.o_read_tag, t_rd);
    end
    step_a(0, 5'd2, 5'd0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'hDEAD_BEEF || bus_a.o_read_tag !== t_rd) begin
      n_fail++; $display("FAIL read_hold: got rs1=%h tag=%h expected deadbeef %h",
                         bus_a.o_rs1, bus_a.o_read_tag, t_rd);
    end
  endtask

  task automatic test_bypass();
    step_a(1, 5'd7, 5'd0, 0, 0, 1, 5'd7, 32'h1234_5678);
    n_checks++;
    if (bus_a.o_rs1 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL bypass: got %h expected 12345678", bus_a.o_rs1);
    end
  endtask

  task automatic test_scoreboard();
    step_a(0, 0, 0, 1, 5'd9, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_busy[9] !== 1'b1) begin
      n_fail++; $display("FAIL reserve_busy: got %b expected 1", bus_a.o_busy[9]);
    end
    step_a(1, 5'd0, 5'd9, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs2_busy !== 1'b1) begin
      n_fail++; $display("FAIL read_busy: got %b expected 1", bus_a.o_rs2_busy);
    end
    step_a(0, 0, 0, 0, 0, 1, 5'd9, 32'hAAAA_0009);
    n_checks++;
    if (bus_a.o_busy[9] !== 1'b0) begin
      n_fail++; $display("FAIL write_clears: got %b expected 0", bus_a.o_busy[9]);
    end
    step_a(0, 0, 0, 1, 5'd9, 1, 5'd9, 32'hBBBB_0009);
    n_checks++;
    if (bus_a.o_busy[9] !== 1'b1) begin
      n_fail++; $display("FAIL reserve_wins: got %b expected 1", bus_a.o_busy[9]);
    end
    step_a(1, 5'd9, 5'd0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'hBBBB_0009 || bus_a.o_rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL reserve_write_data: got %h busy=%b expected bbbb0009 busy=1",
                         bus_a.o_rs1, bus_a.o_rs1_busy);
    end
  endtask

  task automatic test_x0_wrap();
    step_a(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    step_a(1, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'h0 || bus_a.o_rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL x0_read: got %h busy=%b expected 0", bus_a.o_rs1, bus_a.o_rs1_busy);
    end
    step_a(0, 0, 0, 1, 5'd0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL x0_reserve: got %b expected 0", bus_a.o_busy[0]);
    end
    while (t_wr != 4'd14) step_a(0, 0, 0, 0, 0, 1, 5'd20, {28'h0, t_wr});
    step_a(0, 0, 0, 0, 0, 1, 5'd21, 32'h0000_0F15);
    step_a(0, 0, 0, 0, 0, 1, 5'd22, 32'h0000_0F00);
    step_a(0, 0, 0, 0, 0, 1, 5'd23, 32'h0000_0F01);
    step_a(1, 5'd21, 5'd22, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'h0000_0F15 || bus_a.o_rs2 !== 32'h0000_0F00) begin
      n_fail++; $display("FAIL wrap_15_0: got %h %h expected 00000f15 00000f00", bus_a.o_rs1, bus_a.o_rs2);
    end
    step_a(1, 5'd23, 5'd0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (bus_a.o_rs1 !== 32'h0000_0F01) begin
      n_fail++; $display("FAIL wrap_1: got %h expected 00000f01", bus_a.o_rs1);
    end
  endtask

  task automatic test_random();
    bit re, se, we;
    logic [4:0] a, b, s, w;
    int hi;
    for (int c = 0; c < 300; c++) begin
      hi = (c < 150) ? 7 : 31;
      re = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, hi));
      b = 5'($urandom_range(0, hi));
      s = 5'($urandom_range(0, hi));
      w = 5'($urandom_range(0, hi));
      step_a(re, a, b, se, s, we, w, $urandom);
      n_checks++;
      if (bus_a.o_rs1 !== m_rs1 || bus_a.o_rs2 !== m_rs2) begin
        n_fail++; $display("FAIL rand_data c=%0d: got %h %h expected %h %h",
                           c, bus_a.o_rs1, bus_a.o_rs2, m_rs1, m_rs2);
      end
      n_checks++;
      if (bus_a.o_rs1_busy !== m_rs1_busy || bus_a.o_rs2_busy !== m_rs2_busy) begin
        n_fail++; $display("FAIL rand_rbusy c=%0d: got %b%b expected %b%b",
                           c, bus_a.o_rs1_busy, bus_a.o_rs2_busy, m_rs1_busy, m_rs2_busy);
      end
      n_checks++;
      if (bus_a.o_read_tag !== m_rtag) begin
        n_fail++; $display("FAIL rand_tag c=%0d: got %h expected %h", c, bus_a.o_read_tag, m_rtag);
      end
      n_checks++;
      if (bus_a.o_busy !== m_busy) begin
        n_fail++; $display("FAIL rand_busy c=%0d: got %h expected %h", c, bus_a.o_busy, m_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e1, e2;
    step_a(0, 0, 0, 0, 0, 1, 5'd4, 32'hA5A5_A5A5);
    step_a(1, 5'd4, 5'd4, 1, 5'd4, 0, 0, 32'h0);
    #2;
    i_reset_n = 1'b0;
    bus_a.i_read_tag = '0; bus_a.i_reserve_tag = '0; bus_a.i_write_tag = '0;
    #1;
    n_checks++;
    if ({bus_a.o_rs1, bus_a.o_rs2, bus_a.o_rs1_busy, bus_a.o_rs2_busy, bus_a.o_read_tag} !== 70'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got rs1=%h rs2=%h tag=%h expected all zero",
                         bus_a.o_rs1, bus_a.o_rs2, bus_a.o_read_tag);
    end
    n_checks++;
    if (bus_a.o_busy !== 32'h0) begin
      n_fail++; $display("FAIL midreset_busy: got %h expected 0", bus_a.o_busy);
    end
    @(negedge i_clock);
    i_reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      step_a(1, 5'(2 * i), 5'(2 * i + 1), 0, 0, 0, 0, 32'h0);
      e1 = (i == 1) ? 32'h0001_03FC : 32'h0;
      e2 = 32'h0;
      n_checks++;
      if (bus_a.o_rs1 !== e1 || bus_a.o_rs2 !== e2) begin
        n_fail++; $display("FAIL midreset_regs i=%0d: got %h %h expected %h %h",
                           i, bus_a.o_rs1, bus_a.o_rs2, e1, e2);
      end
    end
  endtask

  task automatic test_param_b();
    bus_b.i_write_tag = 4'd1; bus_b.i_write_rd_idx = 4'd7; bus_b.i_rd = 64'h1234_5678;
    bus_b.i_read_tag = 4'd1;  bus_b.i_read_rs1_idx = 4'd7; bus_b.i_read_rs2_idx = 4'd0;
    @(posedge i_clock); @(negedge i_clock);
    n_checks++;
    if (bus_b.o_rs1 !== 64'h0) begin
      n_fail++; $display("FAIL nobypass_old: got %h expected 0", bus_b.o_rs1);
    end
    bus_b.i_read_tag = 4'd2;
    @(posedge i_clock); @(negedge i_clock);
    n_checks++;
    if (bus_b.o_rs1 !== 64'h1234_5678) begin
      n_fail++; $display("FAIL nobypass_next: got %h expected 12345678", bus_b.o_rs1);
    end
    bus_b.i_write_tag = 4'd2; bus_b.i_write_rd_idx = 4'd15; bus_b.i_rd = 64'h0123_4567_89AB_CDEF;
    @(posedge i_clock); @(negedge i_clock);
    bus_b.i_read_tag = 4'd3; bus_b.i_read_rs1_idx = 4'd15; bus_b.i_read_rs2_idx = 4'd2;
    @(posedge i_clock); @(negedge i_clock);
    n_checks++;
    if (bus_b.o_rs1 !== 64'h0123_4567_89AB_CDEF || bus_b.o_rs2 !== 64'h0001_03FC) begin
      n_fail++; $display("FAIL wide_roundtrip: got %h %h expected 0123456789abcdef 00000000000103fc",
                         bus_b.o_rs1, bus_b.o_rs2);
    end
    bus_b.i_reserve_tag = 4'd1; bus_b.i_reserve_rd_idx = 4'd15;
    @(posedge i_clock); @(negedge i_clock);
    n_checks++;
    if (bus_b.o_busy !== 16'h8000) begin
      n_fail++; $display("FAIL wide_busy: got %h expected 8000", bus_b.o_busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_x0_wrap();
    test_random();
    test_reset_mid();
    test_param_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_register_file_mp.md
# cpu_register_file_mp

Parametrised successor to the Rv32H integer register file: a tag-handshaked, multi-register store with two read ports, one write port, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (reads and reserves), writeback (writes) and the hazard logic, which consumes the busy flags to stall.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- REG_COUNT, 32, number of registers; power of two, ≥ 2; IDX_W = clog2(REG_COUNT)
- TAG_WIDTH, 4, width of all request tags
- SP_INDEX, 2, register loaded with SP_RESET at reset
- SP_RESET, 32'h0001_03FC, reset value of register SP_INDEX (truncated/zero-extended to DATA_WIDTH)
- BYPASS, 1, 1 = forward same-cycle write data to reads; 0 = read returns pre-write array value

Ports:
- i_clock  in  1  clock; all state updates on rising edge
- i_reset_n  in  1  asynchronous reset, active-low
- i_read_tag  in  TAG_WIDTH  read request; new request when it differs from the last accepted read tag
- i_read_rs1_idx  in  IDX_W  read port 1 index
- i_read_rs2_idx  in  IDX_W  read port 2 index
- o_rs1  out  DATA_WIDTH  read port 1 data
- o_rs2  out  DATA_WIDTH  read port 2 data
- o_rs1_busy  out  1  rs1 had a pending write when read
- o_rs2_busy  out  1  rs2 had a pending write when read
- o_read_tag  out  TAG_WIDTH  tag of the read whose results are on o_rs1/o_rs2
- i_reserve_tag  in  TAG_WIDTH  reserve request; new when it differs from last accepted
- i_reserve_rd_idx  in  IDX_W  register to mark pending
- i_write_tag  in  TAG_WIDTH  write request; new when it differs from last accepted
- i_write_rd_idx  in  IDX_W  destination index
- i_rd  in  DATA_WIDTH  write data
- o_busy  out  REG_COUNT  scoreboard vector, bit n = register n pending

## Operation
- Three independent request channels (read, reserve, write). Each holds an internal last-accepted tag. A channel acts in a cycle only when its input tag ≠ stored tag, then stores the input tag. A held tag means no new request; tag wrap-around is harmless because only inequality is compared.
- Register 0 is hardwired zero: reads return 0, busy flag 0; writes and reserves to index 0 are discarded, but their tags are still accepted.
- Write accept (rd ≠ 0): r[rd] ← i_rd; busy[rd] ← 0.
- Reserve accept (rd ≠ 0): busy[rd] ← 1.
- Same-cycle reserve and write to the same rd: data is written, busy[rd] ends at 1 (the newer producer wins).
- Read accept, per port with index idx:
  - data = 0 if idx = 0;
  - else i_rd if BYPASS = 1 and a write to the same idx is accepted this cycle;
  - else r[idx].
  - busy output = busy[idx] after this cycle's write and reserve updates: a same-cycle write clears it, a same-cycle reserve sets it, and reserve wins over write.
  - o_read_tag ← i_read_tag.
- No read accepted: o_rs1, o_rs2, o_rs*_busy and o_read_tag hold.
- Reset (i_reset_n = 0, immediate, asynchronous):
  - all registers 0 except r[SP_INDEX] = SP_RESET;
  - o_busy = 0;
  - all stored tags = 0;
  - o_rs1 = o_rs2 = 0, o_rs1_busy = o_rs2_busy = 0, o_read_tag = 0.
- A request pending while reset is asserted is lost. After release, the first request needs a tag ≠ 0.

## Timing
- Read latency: 1 cycle. Outputs are valid the clock after the tag change; o_read_tag matching the issued tag marks completion.
- Write visible to a read accepted in the same cycle only via the bypass. With BYPASS = 0, the write is visible to reads accepted from the next cycle on.
- o_busy is registered and reflects updates 1 cycle after acceptance.
- One operation per channel per cycle. All three channels may fire in the same cycle.
- Deassertion of i_reset_n is synchronised externally; this block is not required to handle metastability.

## Test plan
- Reset: pulse i_reset_n low mid-run → r[2] = 32'h0001_03FC, all other registers 0, o_busy = 0, all outputs 0, with no clock edge required.
- Write then read:
  - write tag 1, rd = 5, data = 32'hDEAD_BEEF; next cycle read tag 1, rs1 = 5, rs2 = 0 → o_rs1 = DEADBEEF, o_rs2 = 0, o_read_tag = 1.
  - hold read tag 1 with rs1 changed to 2 → outputs unchanged.
- Bypass:
  - BYPASS = 1: write rd = 7, data = 32'h1234_5678 in the same cycle as a read of rs1 = 7 → o_rs1 = 12345678.
  - BYPASS = 0 build: same stimulus → o_rs1 = old value 0.
- Scoreboard:
  - reserve rd = 9 → o_busy[9] = 1; read of rs2 = 9 → o_rs2_busy = 1.
  - write rd = 9 → o_busy[9] = 0.
  - reserve and write rd = 9 in the same cycle → o_busy[9] = 1, r[9] updated.
- x0 and wrap:
  - write rd = 0, data = 32'hFFFF_FFFF → read rs1 = 0 returns 0; reserve rd = 0 leaves o_busy[0] = 0.
  - cycle the write tag 15 → 0 → 1 with a new write each step → all three writes accepted.
- Parametrisation: DATA_WIDTH = 64, REG_COUNT = 16 → write/read of r[15] = 64'h0123_4567_89AB_CDEF round-trips, and o_busy is 16 bits wide.
